// File: rtl/lsu_hs.sv
// lsu_hs: handshaked load/store unit that builds byte enables and replicated store data, extends load data,
// and stalls the core while the memory grant and response are outstanding.
// Optional build macro LSU_TIMEOUT_EN adds a request/response timeout that aborts with bus_err.
module lsu_hs #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            stall,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            misalign_err,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            r_state, w_next;
    logic              r_we, r_uns, r_berr;
    logic [1:0]        r_size;
    logic [OB-1:0]     r_off;
    logic [XLEN-1:0]   r_addr, r_wdata, r_rdata;
    logic [NB-1:0]     r_be;

    logic              w_legal, w_aligned, w_fire, w_abort;
    logic [XLEN-1:0]   w_amask, w_rep, w_sh, w_ext;
    logic signed [XLEN-1:0] w_sx;
    logic [NB-1:0]     w_bm, w_be;
    logic [7:0]        w_sa;

    assign w_legal   = (req_size != 2'b11) || (XLEN == 64);
    assign w_amask   = (XLEN'(1) << req_size) - XLEN'(1);
    assign w_aligned = w_legal && ((req_addr & w_amask) == '0);
    assign w_fire    = (r_state == IDLE) && req_valid && w_aligned;

    assign w_bm  = req_size == 2'd0 ? NB'(1) : req_size == 2'd1 ? NB'(3) : req_size == 2'd2 ? NB'(15) : '1;
    assign w_be  = w_bm << req_addr[OB-1:0];
    assign w_rep = req_size == 2'd0 ? {NB{req_wdata[7:0]}} :
                   req_size == 2'd1 ? {(NB/2){req_wdata[15:0]}} :
                   req_size == 2'd2 ? {(NB/4){req_wdata[31:0]}} : req_wdata;

    // Load lane at the captured offset is moved to bit 0, then zero- or sign-extended by shifting.
    assign w_sh  = mem_rdata >> {r_off, 3'b000};
    assign w_sa  = 8'(XLEN) - (8'd8 << r_size);
    assign w_sx  = $signed(w_sh << w_sa) >>> w_sa;
    assign w_ext = r_uns ? (w_sh & ({XLEN{1'b1}} >> w_sa)) : w_sx;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    assign w_abort = ((r_state == REQ) || (r_state == WAIT)) && (r_cnt == CW'(TIMEOUT_CYC - 1));
    // Cycles spent in REQ/WAIT for the current transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else if (w_fire) r_cnt <= '0;
        else if ((r_state == REQ) || (r_state == WAIT)) r_cnt <= r_cnt + 1'b1;
    end
`else
    assign w_abort = (TIMEOUT_CYC < 0);
`endif

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next-state: IDLE -> REQ -> (store) DONE | (load) WAIT -> DONE -> IDLE; timeout forces DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_fire ? REQ : IDLE;
            REQ:     w_next = mem_gnt ? (r_we ? DONE : WAIT) : REQ;
            WAIT:    w_next = mem_rvalid ? DONE : WAIT;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = DONE;
    end

    // Request capture, memory-side registers and the response data/error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= '0;
            r_off   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_berr  <= 1'b0;
        end else if (w_fire) begin
            r_we    <= req_we;
            r_uns   <= req_unsigned;
            r_size  <= req_size;
            r_off   <= req_addr[OB-1:0];
            r_addr  <= {req_addr[XLEN-1:OB], {OB{1'b0}}};
            r_wdata <= w_rep;
            r_be    <= w_be;
            r_rdata <= '0;
            r_berr  <= 1'b0;
        end else if (w_abort) begin
            r_rdata <= '0;
            r_berr  <= 1'b1;
        end else if ((r_state == WAIT) && mem_rvalid) begin
            r_rdata <= w_ext;
        end
    end

    assign stall        = w_fire || (r_state == REQ) || (r_state == WAIT);
    assign misalign_err = (r_state == IDLE) && req_valid && !w_aligned;
    assign rsp_valid    = (r_state == DONE);
    assign rsp_rdata    = (r_state == DONE) ? r_rdata : '0;
    assign bus_err      = (r_state == DONE) && r_berr;
    assign mem_req      = (r_state == REQ);
    assign mem_we       = (r_state == REQ) && r_we;
    assign mem_addr     = r_addr;
    assign mem_be       = r_be;
    assign mem_wdata    = r_wdata;
endmodule

// File: tb/tb_lsu_hs.sv
// tb_lsu_hs: table-driven scoreboard bench for lsu_hs (XLEN=32 main instance, XLEN=64 side instance).
module tb_lsu_hs;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_we, req_unsigned, mem_gnt, mem_rvalid;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic        stall, rsp_valid, misalign_err, bus_err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        q_req_valid, q_req_we, q_req_unsigned, q_mem_gnt, q_mem_rvalid;
    logic [1:0]  q_req_size;
    logic [63:0] q_req_addr, q_req_wdata, q_mem_rdata;
    logic        q_stall, q_rsp_valid, q_misalign_err, q_bus_err, q_mem_req, q_mem_we;
    logic [63:0] q_rsp_rdata, q_mem_addr, q_mem_wdata;
    logic [7:0]  q_mem_be;

    lsu_hs #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .misalign_err(misalign_err), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_hs #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .req_valid(q_req_valid), .req_we(q_req_we), .req_size(q_req_size),
        .req_unsigned(q_req_unsigned), .req_addr(q_req_addr), .req_wdata(q_req_wdata), .stall(q_stall),
        .rsp_valid(q_rsp_valid), .rsp_rdata(q_rsp_rdata), .misalign_err(q_misalign_err), .bus_err(q_bus_err),
        .mem_req(q_mem_req), .mem_we(q_mem_we), .mem_addr(q_mem_addr), .mem_be(q_mem_be), .mem_wdata(q_mem_wdata),
        .mem_gnt(q_mem_gnt), .mem_rvalid(q_mem_rvalid), .mem_rdata(q_mem_rdata)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr, wdata, rdata;
        int          gd, rd;
        logic        err;
        logic [3:0]  be;
        logic [31:0] maddr, mwdata, exp;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int g, w, stalls, exp_stalls;
        bit wt, seen, done;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_size = v.sz; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        if (v.err) begin
            chk("misalign_err", misalign_err, 1);
            chk("err_stall", stall, 0);
            chk("err_mem_req", mem_req, 0);
            @(negedge clk);
            req_valid = 1'b0;
            #1 chk("err_no_req_later", mem_req, 0);
            return;
        end
        chk("capture_stall", stall, 1);
        chk("capture_misalign", misalign_err, 0);
        sb_q.push_back(v.exp);
        exp_stalls = v.we ? 2 + v.gd : 3 + v.gd + v.rd;
        stalls = 1; g = 0; w = 0; wt = 0; seen = 0; done = 0;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            mem_rvalid = wt && (w == v.rd);
            mem_rdata  = mem_rvalid ? v.rdata : 32'h5A5A_5A5A;
            if (wt) begin
                w++;
                if (mem_rvalid) wt = 0;
            end
            mem_gnt = mem_req && (g == v.gd);
            if (mem_req && !seen) begin
                seen = 1;
                chk("mem_addr", mem_addr, v.maddr);
                chk("mem_be", mem_be, v.be);
                chk("mem_wdata", mem_wdata, v.mwdata);
                chk("mem_we", mem_we, v.we);
            end
            if (mem_req) g++;
            if (mem_gnt && !v.we) begin wt = 1; w = 0; end
            #1;
            if (rsp_valid) begin
                done = 1;
                chk("rsp_rdata", rsp_rdata, sb_q.pop_front());
                chk("stall_cycles", stalls, exp_stalls);
                chk("done_stall", stall, 0);
                chk("done_bus_err", bus_err, 0);
            end else begin
                if (stall) stalls++;
                chk("rdata_idle_zero", rsp_rdata, 0);
            end
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 64 cycles");
            sb_q.delete();
        end
        @(negedge clk);
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("after_done_rsp", rsp_valid, 0);
        chk("after_done_stall", stall, 0);
    endtask

    task automatic run64(input logic we, input logic [1:0] sz, input logic uns, input logic [63:0] addr,
                         input logic [63:0] rdata, input logic [7:0] be, input logic [63:0] exp);
        @(negedge clk);
        q_req_valid = 1'b1; q_req_we = we; q_req_size = sz; q_req_unsigned = uns;
        q_req_addr = addr; q_req_wdata = '0;
        #1 chk("q_capture_stall", q_stall, 1);
        @(negedge clk);
        chk("q_mem_req", q_mem_req, 1);
        chk("q_mem_be", q_mem_be, be);
        chk("q_mem_addr", q_mem_addr, {addr[63:3], 3'b000});
        q_mem_gnt = 1'b1;
        @(negedge clk);
        q_mem_gnt = 1'b0; q_mem_rvalid = 1'b1; q_mem_rdata = rdata;
        @(negedge clk);
        q_mem_rvalid = 1'b0;
        #1;
        chk("q_rsp_valid", q_rsp_valid, 1);
        chk("q_rsp_rdata", q_rsp_rdata, exp);
        @(negedge clk);
        q_req_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        int good;
        tv[0]  = '{1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00A5, 32'h0,         0, 0, 1'b0, 4'b1000, 32'h100, 32'hA5A5_A5A5, 32'h0};
        tv[1]  = '{1'b0, 2'd1, 1'b0, 32'h202, 32'h0,         32'h8001_1234, 3, 0, 1'b0, 4'b1100, 32'h200, 32'h0,         32'hFFFF_8001};
        tv[2]  = '{1'b0, 2'd1, 1'b1, 32'h202, 32'h0,         32'h8001_1234, 3, 0, 1'b0, 4'b1100, 32'h200, 32'h0,         32'h0000_8001};
        tv[3]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0,         32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,   32'h0,         32'h0};
        tv[4]  = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0,         32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,   32'h0,         32'h0};
        tv[5]  = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0,         32'h0000_8000, 0, 1, 1'b0, 4'b0010, 32'h100, 32'h0,         32'hFFFF_FF80};
        tv[6]  = '{1'b0, 2'd0, 1'b1, 32'h107, 32'h0,         32'hFE00_0000, 1, 0, 1'b0, 4'b1000, 32'h104, 32'h0,         32'h0000_00FE};
        tv[7]  = '{1'b1, 2'd1, 1'b0, 32'h006, 32'h1234_5678, 32'h0,         2, 0, 1'b0, 4'b1100, 32'h004, 32'h5678_5678, 32'h0};
        tv[8]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEAD_BEEF, 32'h0,         0, 0, 1'b0, 4'b1111, 32'h010, 32'hDEAD_BEEF, 32'h0};
        tv[9]  = '{1'b0, 2'd2, 1'b0, 32'h020, 32'h0,         32'h8765_4321, 0, 2, 1'b0, 4'b1111, 32'h020, 32'h0,         32'h8765_4321};
        tv[10] = '{1'b0, 2'd1, 1'b0, 32'h001, 32'h0,         32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,   32'h0,         32'h0};
        tv[11] = '{1'b0, 2'd0, 1'b0, 32'h000, 32'h0,         32'h0000_007F, 0, 0, 1'b0, 4'b0001, 32'h000, 32'h0,         32'h0000_007F};

        rst = 1'b0;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        q_req_valid = 0; q_req_we = 0; q_req_size = 0; q_req_unsigned = 0; q_req_addr = 0; q_req_wdata = 0;
        q_mem_gnt = 0; q_mem_rvalid = 0; q_mem_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", stall, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_mem_be", mem_be, 0);
        chk("reset_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) run(tv[i]);

        // reset while a load is waiting for its data
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h40;
        #1 chk("rstw_capture", stall, 1);
        @(negedge clk);
        mem_gnt = mem_req;
        @(negedge clk);
        mem_gnt = 0;
        #1;
        chk("rstw_in_wait_req", mem_req, 0);
        chk("rstw_in_wait_stall", stall, 1);
        req_valid = 0;
        #1 rst = 1'b0;
        #1;
        chk("rstw_stall", stall, 0);
        chk("rstw_mem_req", mem_req, 0);
        chk("rstw_mem_be", mem_be, 0);
        chk("rstw_mem_addr", mem_addr, 0);
        chk("rstw_mem_wdata", mem_wdata, 0);
        chk("rstw_rsp_valid", rsp_valid, 0);
        chk("rstw_rsp_rdata", rsp_rdata, 0);
        chk("rstw_bus_err", bus_err, 0);
        @(negedge clk);
        rst = 1'b1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 0;
        #1;
        chk("rstw_late_rvalid_rsp", rsp_valid, 0);
        chk("rstw_late_rvalid_stall", stall, 0);
        @(negedge clk);
        #1 chk("rstw_late_rvalid_rsp2", rsp_valid, 0);

        // store whose grant never arrives on its own
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h30; req_wdata = 32'h1122_3344;
        #1 chk("nognt_capture", stall, 1);
`ifdef LSU_TIMEOUT_EN
        good = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin good = n; break; end
        end
        chk("timeout_cycle", good, 17);
        chk("timeout_bus_err", bus_err, 1);
        chk("timeout_rdata", rsp_rdata, 0);
        chk("timeout_mem_req", mem_req, 0);
        @(negedge clk);
        req_valid = 0;
        #1 chk("timeout_bus_err_clear", bus_err, 0);
`else
        good = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            #1;
            if (mem_req && stall && !bus_err && !rsp_valid) good++;
        end
        chk("nognt_held_cycles", good, 20);
        @(negedge clk);
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        #1;
        chk("nognt_rsp_valid", rsp_valid, 1);
        chk("nognt_bus_err", bus_err, 0);
        @(negedge clk);
        req_valid = 0;
`endif

        run64(1'b0, 2'd3, 1'b0, 64'h08, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF);
        run64(1'b0, 2'd2, 1'b0, 64'h0C, 64'h8000_0000_0000_0000, 8'hF0, 64'hFFFF_FFFF_8000_0000);
        run64(1'b0, 2'd1, 1'b1, 64'h0E, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h0000_0000_0000_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
